// File: rtl/pendigits_tnn.sv
// Ternary-weight pen-digits classifier: 40 binary hidden neurons, 10 ternary class scores, argmax.
// Optional macro PENDIGITS_TNN_SCORES_EN exposes the registered class scores on port `scores`.
module pendigits_tnn #(
    parameter int N = 16,
    parameter int B = 4,
    parameter int M = 40,
    parameter int C = 10,
    parameter logic [M*N-1:0] W1P = '0,
    parameter logic [M*N-1:0] W1N = '0,
    parameter logic [C*M-1:0] W2P = '0,
    parameter logic [C*M-1:0] W2N = '0,
    localparam int KW = $clog2(C),
    localparam int SW = $clog2(N * ((1 << B) - 1) + 1) + 1,
    localparam int YW = $clog2(M + 1) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [N*B-1:0]  inp,
    output logic            out_valid,
    output logic [KW-1:0]   klass
`ifdef PENDIGITS_TNN_SCORES_EN
    ,
    output logic [C*YW-1:0] scores
`endif
);

    logic [M-1:0]    h_d, h_q;
    logic            v1_d, v1_q;
    logic            out_valid_d, out_valid_q;
    logic [KW-1:0]   klass_d, klass_q;
    logic [C*YW-1:0] y_all;
    logic [KW-1:0]   best_idx;

    // Stage 1: signed pre-activation per neuron; the sign bit alone decides h (zero counts as active).
    for (genvar gi = 0; gi < M; gi++) begin : g_hidden
        logic signed [SW-1:0] s;
        always_comb begin
            s = '0;
            for (int i = 0; i < N; i++) begin
                if (W1P[gi*N+i] && !W1N[gi*N+i]) begin
                    s = s + $signed(SW'(inp[i*B +: B]));
                end else if (W1N[gi*N+i] && !W1P[gi*N+i]) begin
                    s = s - $signed(SW'(inp[i*B +: B]));
                end
            end
        end
        assign h_d[gi] = ~s[SW-1];
    end

    // Stage 2: each class score is a signed count of active +1 / -1 connections.
    for (genvar gi = 0; gi < C; gi++) begin : g_class
        logic signed [YW-1:0] y;
        always_comb begin
            y = '0;
            for (int j = 0; j < M; j++) begin
                if (h_q[j] && W2P[gi*M+j] && !W2N[gi*M+j]) begin
                    y = y + YW'(1);
                end else if (h_q[j] && W2N[gi*M+j] && !W2P[gi*M+j]) begin
                    y = y - YW'(1);
                end
            end
        end
        assign y_all[gi*YW +: YW] = y;
    end

    // Strict greater-than keeps the lowest index on ties.
    always_comb begin
        logic signed [YW-1:0] best;
        best     = $signed(y_all[YW-1:0]);
        best_idx = '0;
        for (int c = 1; c < C; c++) begin
            if ($signed(y_all[c*YW +: YW]) > best) begin
                best     = $signed(y_all[c*YW +: YW]);
                best_idx = KW'(c);
            end
        end
    end

    always_comb begin
        v1_d        = in_valid;
        out_valid_d = v1_q;
        klass_d     = v1_q ? best_idx : klass_q;
    end

`ifdef PENDIGITS_TNN_SCORES_EN
    logic [C*YW-1:0] scores_d, scores_q;
    always_comb begin
        scores_d = v1_q ? y_all : scores_q;
    end
    assign scores = scores_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q         <= '0;
            v1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            klass_q     <= '0;
`ifdef PENDIGITS_TNN_SCORES_EN
            scores_q    <= '0;
`endif
        end else begin
            h_q         <= h_d;
            v1_q        <= v1_d;
            out_valid_q <= out_valid_d;
            klass_q     <= klass_d;
`ifdef PENDIGITS_TNN_SCORES_EN
            scores_q    <= scores_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign klass     = klass_q;

endmodule

// File: tb/tb_pendigits_tnn.sv
// Scoreboard bench for pendigits_tnn: four instances (zero, directed, tie and pseudo-random weights)
// share one random input stream; a monitor pops expected results as each instance reports them.
module tb_pendigits_tnn;
    localparam int N  = 16;
    localparam int B  = 4;
    localparam int M  = 40;
    localparam int C  = 10;
    localparam int YW = 7;
    localparam int ND = 4;

    function automatic logic [M*N-1:0] prand(input logic [31:0] seed);
        logic [M*N-1:0] r;
        logic [31:0]    s;
        r = '0;
        s = seed;
        for (int i = 0; i < M*N; i++) begin
            s    = s * 32'd1664525 + 32'd1013904223;
            r[i] = s[28];
        end
        return r;
    endfunction

    function automatic logic [M*N-1:0] sel_w1p(input int k);
        case (k)
            1, 2:    return (M*N)'(1);
            3:       return prand(32'h0000_1234);
            default: return '0;
        endcase
    endfunction

    function automatic logic [M*N-1:0] sel_w1n(input int k);
        case (k)
            1:       return (M*N)'(16'hFFFF) << N;
            3:       return prand(32'h0000_9876);
            default: return '0;
        endcase
    endfunction

    function automatic logic [C*M-1:0] sel_w2p(input int k);
        case (k)
            1:       return (C*M)'(1) << (3*M);
            2:       return ((C*M)'(1) << (7*M)) | ((C*M)'(1) << (2*M));
            3:       return (C*M)'(prand(32'h0000_5555));
            default: return '0;
        endcase
    endfunction

    function automatic logic [C*M-1:0] sel_w2n(input int k);
        case (k)
            1:       return (C*M)'(1) << (5*M+1);
            3:       return (C*M)'(prand(32'h0000_ABCD));
            default: return '0;
        endcase
    endfunction

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [N*B-1:0]   inp;
    logic             ov [ND];
    logic [3:0]       kl [ND];
`ifdef PENDIGITS_TNN_SCORES_EN
    logic [C*YW-1:0]  sc [ND];
`endif

    for (genvar gi = 0; gi < ND; gi++) begin : g_dut
        pendigits_tnn #(
            .N(N), .B(B), .M(M), .C(C),
            .W1P(sel_w1p(gi)), .W1N(sel_w1n(gi)),
            .W2P(sel_w2p(gi)), .W2N(sel_w2n(gi))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .inp      (inp),
            .out_valid(ov[gi]),
            .klass    (kl[gi])
`ifdef PENDIGITS_TNN_SCORES_EN
            ,
            .scores   (sc[gi])
`endif
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [3:0]      k;
        logic [C*YW-1:0] s;
        int              due;
    } exp_t;

    exp_t       q [ND][$];
    logic [3:0] last_k [ND];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic chk(input string nm, input int k, input logic [C*YW-1:0] act, input logic [C*YW-1:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s dut%0d cyc%0d: got %h want %h", nm, k, cyc, act, want);
        end
    endtask

    function automatic int wt(input logic p, input logic n);
        if (p && !n) return 1;
        if (n && !p) return -1;
        return 0;
    endfunction

    // Reference model straight from the arithmetic definition, using plain integers.
    task automatic model(input int k, input logic [N*B-1:0] x, output logic [3:0] ek, output logic [C*YW-1:0] es);
        logic [M*N-1:0] p1, n1;
        logic [C*M-1:0] p2, n2;
        int h [M];
        int y [C];
        int s, best;
        p1 = sel_w1p(k); n1 = sel_w1n(k);
        p2 = sel_w2p(k); n2 = sel_w2n(k);
        for (int j = 0; j < M; j++) begin
            s = 0;
            for (int i = 0; i < N; i++) s += wt(p1[j*N+i], n1[j*N+i]) * int'(x[i*B +: B]);
            h[j] = (s >= 0) ? 1 : 0;
        end
        es = '0;
        for (int c = 0; c < C; c++) begin
            y[c] = 0;
            for (int j = 0; j < M; j++) y[c] += wt(p2[c*M+j], n2[c*M+j]) * h[j];
            es[c*YW +: YW] = YW'(y[c]);
        end
        best = 0;
        for (int c = 1; c < C; c++) if (y[c] > y[best]) best = c;
        ek = 4'(best);
    endtask

    task automatic issue(input logic v, input logic [N*B-1:0] x);
        logic [3:0]      ek;
        logic [C*YW-1:0] es;
        @(negedge clk);
        in_valid = v;
        inp      = x;
        if (v) begin
            for (int k = 0; k < ND; k++) begin
                model(k, x, ek, es);
                q[k].push_back('{k: ek, s: es, due: cyc + 2});
            end
        end
    endtask

    function automatic logic [N*B-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < ND; k++) begin
                if (ov[k]) begin
                    if (q[k].size() == 0) begin
                        chk("spurious_out_valid", k, 1, 0);
                    end else begin
                        exp_t e;
                        e = q[k].pop_front();
                        chk("latency", k, cyc, e.due);
                        chk("klass", k, kl[k], e.k);
`ifdef PENDIGITS_TNN_SCORES_EN
                        chk("scores", k, sc[k], e.s);
`endif
                        last_k[k] = e.k;
                    end
                end else begin
                    if (q[k].size() > 0 && q[k][0].due <= cyc) begin
                        chk("missing_out_valid", k, 0, 1);
                        void'(q[k].pop_front());
                    end
                    chk("klass_hold", k, kl[k], last_k[k]);
                end
            end
        end
    end

    localparam logic [N*B-1:0] SPEC_VEC [5] = '{
        64'h8f4d96400498fe6f, 64'h0e4f7c572260b0f1, 64'h095bceffcc884430,
        64'h0f1f1b37e5f7c4b0, 64'h0b8dffddaa665380
    };

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        inp      = '0;
        for (int k = 0; k < ND; k++) last_k[k] = 4'd0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            chk("reset_out_valid", k, ov[k], 0);
            chk("reset_klass", k, kl[k], 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 5; i++) issue(1'b1, SPEC_VEC[i]);
        issue(1'b1, 64'h0);
        issue(1'b1, 64'hF);
        for (int i = 0; i < 10; i++) issue(i % 2 == 0, rnd64());
        for (int i = 0; i < 150; i++) issue($urandom_range(0, 3) != 0, rnd64());

        // Asynchronous reset with two samples in the pipe.
        issue(1'b1, rnd64());
        issue(1'b1, rnd64());
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            chk("async_reset_out_valid", k, ov[k], 0);
            chk("async_reset_klass", k, kl[k], 0);
`ifdef PENDIGITS_TNN_SCORES_EN
            chk("async_reset_scores", k, sc[k], 0);
`endif
            q[k].delete();
            last_k[k] = 4'd0;
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 60; i++) issue($urandom_range(0, 2) != 0, rnd64());
        for (int i = 0; i < 6; i++) issue(1'b0, rnd64());
        for (int k = 0; k < ND; k++) chk("drain_empty", k, q[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
